fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the word address to the combinational instruction memory, and captures the returned instruction plus PC+4 into the IF/ID pipeline register. Accepts stall and flush from the hazard unit and branch/jump redirects from the decode stage. Stops fetching once the PC leaves the populated instruction-memory range.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: PC register plus IF/ID pipeline register; stops fetching once the PC leaves the populated imem range.
// Latency one edge pc->ifid; stall holds PC and IF/ID, redirect overrides stall, flush turns the next IF/ID load into a bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 16,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush_ifid,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      fetch_addr,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      ifid_inst,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [31:0]      RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [29:0]      IMEM_LIMIT = 30'(IMEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_inst_q, ifid_inst_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        in_range;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_range = (pc_q[31:2] < IMEM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC_W;
      ifid_inst_q   <= 32'd0;
      ifid_pc4_q    <= 32'd0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // A taken redirect always restarts fetching, even toward an out-of-range target.
  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = RUN;
    else if (state_q == RUN && !in_range)
      state_d = HALTED;
  end

  always_comb begin
    pc_d          = pc_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (redirect || state_q == HALTED || !in_range || flush_ifid) begin
      ifid_inst_d  = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (state_q == RUN && in_range && !stall) begin
      pc_d = pc_plus4;
      if (!flush_ifid) begin
        ifid_inst_d  = imem_inst;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
        if (fetch_count_q != CNT_MAX)
          fetch_count_d = fetch_count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    fetch_addr  = {pc_q[31:2], 2'b00};
    ifid_inst   = ifid_inst_q;
    ifid_pc4    = ifid_pc4_q;
    ifid_valid  = ifid_valid_q;
    halted      = (state_q == HALTED);
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random stall/flush/redirect/reset traffic against a behavioural model.
module tb_fetch_unit;

  localparam int IMEM_WORDS = 16;

  logic        clk = 1'b0;
  logic        reset, stall, flush_ifid, redirect;
  logic [31:0] redirect_pc, fetch_addr, imem_inst, ifid_inst, ifid_pc4;
  logic        ifid_valid, halted;
  logic [15:0] fetch_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // behavioural model of the architectural state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid, m_halted;
  int          m_cnt;

  always #5 clk = ~clk;

  // memory tags each word with its own byte address
  assign imem_inst = 32'h1000_0000 | fetch_addr;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(IMEM_WORDS), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_ifid(flush_ifid),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_addr(fetch_addr),
    .imem_inst(imem_inst), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bubble_model();
    m_inst  = 32'd0;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'd0; bubble_model(); m_halted = 1'b0; m_cnt = 0;
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC; bubble_model(); m_halted = 1'b0;
    end else if (m_halted) begin
      bubble_model();
    end else if (m_pc / 4 >= IMEM_WORDS) begin
      bubble_model(); m_halted = 1'b1;
    end else if (stall) begin
      if (flush_ifid) bubble_model();
    end else begin
      if (flush_ifid) bubble_model();
      else begin
        m_inst  = 32'h1000_0000 + m_pc;
        m_pc4   = m_pc + 4;
        m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      m_pc = m_pc + 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fetch_addr",  fetch_addr, m_pc);
      chk("ifid_inst",   ifid_inst, m_inst);
      chk("ifid_pc4",    ifid_pc4, m_pc4);
      chk("ifid_valid",  32'(ifid_valid), 32'(m_valid));
      chk("halted",      32'(halted), 32'(m_halted));
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit stl, input bit fl, input bit rd, input logic [31:0] rpc);
    reset = rst; stall = stl; flush_ifid = fl; redirect = rd; redirect_pc = rpc;
  endtask

  initial begin
    drive(1, 0, 0, 0, 32'h0);
    tick();
    chk_en = 1'b1;
    chk("rst_addr", fetch_addr, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_inst", ifid_inst, 32'h0);
    chk("rst_cnt", 32'(fetch_count), 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    tick();
    chk("f0_inst", ifid_inst, 32'h1000_0000);
    chk("f0_pc4", ifid_pc4, 32'h4);
    tick();
    chk("f1_inst", ifid_inst, 32'h1000_0004);
    chk("f1_addr", fetch_addr, 32'h8);
    // stall two edges at pc 0x8
    drive(0, 1, 0, 0, 32'h0);
    tick(); tick();
    chk("stall_addr", fetch_addr, 32'h8);
    chk("stall_inst", ifid_inst, 32'h1000_0004);
    chk("stall_cnt", 32'(fetch_count), 32'h2);
    drive(0, 0, 0, 0, 32'h0);
    tick();
    chk("resume_inst", ifid_inst, 32'h1000_0008);
    chk("resume_pc4", ifid_pc4, 32'hC);
    chk("resume_cnt", 32'(fetch_count), 32'h3);
    tick();
    chk("pre_redir_addr", fetch_addr, 32'h10);
    drive(0, 0, 0, 1, 32'h0000_0027);
    tick();
    chk("redir_addr", fetch_addr, 32'h24);
    chk("redir_bubble", 32'(ifid_valid), 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    tick();
    chk("redir_inst", ifid_inst, 32'h1000_0024);
    chk("redir_pc4", ifid_pc4, 32'h28);
    repeat (6) tick();
    chk("w15_pc4", ifid_pc4, 32'h40);
    chk("w15_halted", 32'(halted), 32'h0);
    tick();
    chk("halt_valid", 32'(ifid_valid), 32'h0);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_addr", fetch_addr, 32'h40);
    chk("halt_cnt", 32'(fetch_count), 32'd11);
    drive(0, 1, 1, 0, 32'h0);
    tick();
    chk("halt_hold_addr", fetch_addr, 32'h40);
    drive(0, 0, 0, 1, 32'h0);
    tick();
    chk("unhalt_flag", 32'(halted), 32'h0);
    chk("unhalt_addr", fetch_addr, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    tick();
    chk("unhalt_inst", ifid_inst, 32'h1000_0000);
    chk("unhalt_cnt", 32'(fetch_count), 32'd12);
    drive(0, 1, 0, 1, 32'h30);
    tick();
    chk("stall_redir_addr", fetch_addr, 32'h30);
    drive(0, 1, 1, 0, 32'h0);
    tick();
    chk("stall_flush_addr", fetch_addr, 32'h30);
    chk("stall_flush_valid", 32'(ifid_valid), 32'h0);
    drive(0, 0, 0, 1, 32'h20);
    tick();
    chk("at_20", fetch_addr, 32'h20);
    drive(1, 0, 0, 1, 32'h8);
    tick();
    chk("rst_redir_addr", fetch_addr, 32'h0);
    chk("rst_redir_cnt", 32'(fetch_count), 32'h0);
    chk("rst_redir_pc4", ifid_pc4, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    tick();
    chk("post_rst_inst", ifid_inst, 32'h1000_0000);
    drive(0, 0, 1, 0, 32'h0);
    tick();
    chk("flush_addr", fetch_addr, 32'h8);
    chk("flush_valid", 32'(ifid_valid), 32'h0);
    chk("flush_cnt", 32'(fetch_count), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 6,
            32'($urandom_range(0, 95)));
      tick();
    end
    drive(0, 0, 0, 0, 32'h0);
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
